// File: rtl/proc_clk_ctrl_if.sv
// Purpose : control/status bundle between the board-side run controls and
//           the core run controller (proc_clk_ctrl).
// Signals : Mode     2      run mode: 00 HALT, 01 RUN, 10 SLOW, 11 STEP
//           DivVal   DIV_W  slow-run tick period minus 1
//           StepBtn  1      raw asynchronous step/resume button
//           BrkEn    1      breakpoint enable
//           BrkAddr  PC_W   breakpoint address
//           PC       PC_W   core fetch PC
//           ClkEn    1      core clock enable
//           Halted   1      controller is in HALT or BRK
//           BrkHit   1      controller is in BRK
//           CycleCnt CNT_W  enabled cycles since reset, wrapping
// Modports: master drives the controls (board side), slave is the controller.
interface proc_clk_ctrl_if #(
   parameter int DIV_W = 27,
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic [1:0]       Mode;
   logic [DIV_W-1:0] DivVal;
   logic             StepBtn;
   logic             BrkEn;
   logic [PC_W-1:0]  BrkAddr;
   logic [PC_W-1:0]  PC;
   logic             ClkEn;
   logic             Halted;
   logic             BrkHit;
   logic [CNT_W-1:0] CycleCnt;

   modport master (
      output Mode, DivVal, StepBtn, BrkEn, BrkAddr, PC,
      input  ClkEn, Halted, BrkHit, CycleCnt
   );

   modport slave (
      input  Mode, DivVal, StepBtn, BrkEn, BrkAddr, PC,
      output ClkEn, Halted, BrkHit, CycleCnt
   );
endinterface

// File: rtl/proc_clk_ctrl.sv
// Purpose : run controller for the 5-stage core. Generates the core clock
//           enable in HALT, RUN, SLOW (divided tick) and debounced single-step
//           modes, and freezes the core on a PC breakpoint before the
//           breakpoint instruction executes.
// Ports   : Clk  board clock
//           Rst  synchronous active-high reset
//           bus  proc_clk_ctrl_if.slave (controls in, ClkEn/status out)
module proc_clk_ctrl #(
   parameter int DIV_W   = 27,
   parameter int DEB_CNT = 1_000_000,
   parameter int PC_W    = 32,
   parameter int CNT_W   = 32
) (
   input logic           Clk,
   input logic           Rst,
   proc_clk_ctrl_if.slave bus
);

   localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CNT - 1);

   typedef enum logic [2:0] {
      ST_HALT = 3'd0,
      ST_RUN  = 3'd1,
      ST_SLOW = 3'd2,
      ST_STEP = 3'd3,
      ST_BRK  = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             level_d_r;
   logic [DEB_W-1:0] deb_cnt_r;
   logic             step_req_s;
   logic [DIV_W-1:0] div_cnt_r;
   logic             tick_s;
   logic             hit_s;
   logic             skip_r;
   logic             clk_en_s;
   logic             halted_r;
   logic             brk_hit_r;
   logic [CNT_W-1:0] cycle_cnt_r;
   logic [PC_W-1:0]  pc_s;
   logic [PC_W-1:0]  brk_addr_s;

   // Switch position to the state it selects.
   function automatic state_t mode_state(input logic [1:0] m);
      case (m)
         2'b00:   return ST_HALT;
         2'b01:   return ST_RUN;
         2'b10:   return ST_SLOW;
         default: return ST_STEP;
      endcase
   endfunction

   assign pc_s       = bus.PC;
   assign brk_addr_s = bus.BrkAddr;

   // Two-flop synchroniser for the raw step button.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= bus.StepBtn;
         sync2_r <= sync1_r;
      end
   end

   // Debouncer: level follows the synchronised input only after it has
   // disagreed for DEB_CNT consecutive cycles; any agreement restarts the count.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         level_r   <= 1'b0;
         level_d_r <= 1'b0;
         deb_cnt_r <= {DEB_W{1'b0}};
      end else begin
         level_d_r <= level_r;
         if (sync2_r == level_r) begin
            deb_cnt_r <= {DEB_W{1'b0}};
         end else if (deb_cnt_r == DEB_MAX) begin
            level_r   <= sync2_r;
            deb_cnt_r <= {DEB_W{1'b0}};
         end else begin
            deb_cnt_r <= deb_cnt_r + DEB_W'(1'b1);
         end
      end
   end

   assign step_req_s = level_r & ~level_d_r;

   // Slow-run divider: free-runs 0..DivVal only while in SLOW, else parked at 0
   // so entering SLOW always waits a full period for the first tick.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (state_r == ST_SLOW) begin
         if (tick_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
         end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
         end
      end else begin
         div_cnt_r <= {DIV_W{1'b0}};
      end
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= ST_HALT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN, ST_SLOW: begin
            if (hit_s) begin
               state_nxt_s = ST_BRK;
            end else begin
               state_nxt_s = mode_state(bus.Mode);
            end
         end
         ST_BRK: begin
            // Only a step press or the HALT switch leaves a breakpoint.
            if (step_req_s) begin
               state_nxt_s = mode_state(bus.Mode);
            end else if (bus.Mode == 2'b00) begin
               state_nxt_s = ST_HALT;
            end else begin
               state_nxt_s = ST_BRK;
            end
         end
         ST_HALT, ST_STEP: begin
            state_nxt_s = mode_state(bus.Mode);
         end
         default: begin
            state_nxt_s = ST_HALT;
         end
      endcase
   end

   // FSM output logic: clock enable from registered state and live PC/step/tick.
   always_comb begin
      tick_s   = (state_r == ST_SLOW) && (div_cnt_r == bus.DivVal);
      hit_s    = bus.BrkEn && (pc_s == brk_addr_s) && !skip_r;
      clk_en_s = 1'b0;
      case (state_r)
         ST_RUN:  clk_en_s = !hit_s;
         ST_SLOW: clk_en_s = tick_s && !hit_s;
         ST_STEP: clk_en_s = step_req_s;
         ST_BRK:  clk_en_s = step_req_s;
         ST_HALT: clk_en_s = 1'b0;
         default: clk_en_s = 1'b0;
      endcase
   end

   // Breakpoint skip flag: armed by a resume from BRK, dropped on the next
   // enabled cycle so the breakpoint instruction runs once without re-hitting.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         skip_r <= 1'b0;
      end else if ((state_r == ST_BRK) && step_req_s) begin
         skip_r <= 1'b1;
      end else if (clk_en_s) begin
         skip_r <= 1'b0;
      end else begin
         skip_r <= skip_r;
      end
   end

   // Registered status decodes and the enabled-cycle counter.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         halted_r    <= 1'b1;
         brk_hit_r   <= 1'b0;
         cycle_cnt_r <= {CNT_W{1'b0}};
      end else begin
         halted_r  <= (state_nxt_s == ST_HALT) || (state_nxt_s == ST_BRK);
         brk_hit_r <= (state_nxt_s == ST_BRK);
         if (clk_en_s) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1'b1);
         end else begin
            cycle_cnt_r <= cycle_cnt_r;
         end
      end
   end

   assign bus.ClkEn    = clk_en_s;
   assign bus.Halted   = halted_r;
   assign bus.BrkHit   = brk_hit_r;
   assign bus.CycleCnt = cycle_cnt_r;

endmodule

// File: tb/tb_proc_clk_ctrl.sv
// Purpose : directed self-checking bench for proc_clk_ctrl (DEB_CNT=4,
//           CNT_W=4 build). Inputs change 1 time unit after the rising edge,
//           outputs are captured on the falling edge.
module tb_proc_clk_ctrl;

   logic       Clk = 1'b0;
   logic       Rst;
   int         n_chk  = 0;
   int         n_pass = 0;
   logic       en_o;
   logic       halt_o;
   logic       brk_o;
   logic [3:0] cnt_o;
   int         pulses;
   int         first;

   proc_clk_ctrl_if #(.DIV_W(8), .PC_W(32), .CNT_W(4)) bus ();

   proc_clk_ctrl #(
      .DIV_W(8), .DEB_CNT(4), .PC_W(32), .CNT_W(4)
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: capture outputs mid-cycle, then advance the PC model if enabled.
   task automatic cyc();
      @(negedge Clk);
      en_o   = bus.ClkEn;
      halt_o = bus.Halted;
      brk_o  = bus.BrkHit;
      cnt_o  = bus.CycleCnt;
      @(posedge Clk);
      #1;
      if (en_o === 1'b1) bus.PC = bus.PC + 32'd4;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      cyc();
      cyc();
      Rst = 1'b0;
      bus.PC = 32'd0;
   endtask

   initial begin
      Rst         = 1'b1;
      bus.Mode    = 2'b00;
      bus.DivVal  = 8'd0;
      bus.StepBtn = 1'b0;
      bus.BrkEn   = 1'b0;
      bus.BrkAddr = 32'd0;
      bus.PC      = 32'd0;
      @(posedge Clk);
      #1;

      // T1: reset state, full-speed run, mid-run reset
      bus.Mode = 2'b01;
      do_reset();
      cyc();
      chk("t1_rst_en", 32'(en_o), 32'd0);
      chk("t1_rst_halted", 32'(halt_o), 32'd1);
      chk("t1_rst_brk", 32'(brk_o), 32'd0);
      chk("t1_rst_cnt", 32'(cnt_o), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t1_run_en", 32'(en_o), 32'd1);
         chk("t1_run_cnt", 32'(cnt_o), 32'(i));
      end
      cyc();
      chk("t1_cnt10", 32'(cnt_o), 32'd10);
      chk("t1_run_halted", 32'(halt_o), 32'd0);
      Rst = 1'b1;
      cyc();
      Rst = 1'b0;
      cyc();
      chk("t1_midrst_en", 32'(en_o), 32'd0);
      chk("t1_midrst_cnt", 32'(cnt_o), 32'd0);
      chk("t1_midrst_halted", 32'(halt_o), 32'd1);

      // T2: slow run, DivVal=3 then DivVal=0
      bus.Mode   = 2'b10;
      bus.DivVal = 8'd3;
      do_reset();
      cyc();
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk("t2_div3_en", 32'(en_o), ((i % 4) == 3) ? 32'd1 : 32'd0);
         if (en_o === 1'b1) pulses++;
      end
      chk("t2_div3_pulses", 32'(pulses), 32'd4);
      bus.DivVal = 8'd0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t2_div0_en", 32'(en_o), 32'd1);
      end

      // T3: debounced single step
      bus.Mode    = 2'b11;
      bus.StepBtn = 1'b0;
      do_reset();
      cyc();
      cyc();
      chk("t3_step_halted", 32'(halt_o), 32'd0);
      pulses = 0;
      first  = -1;
      for (int i = 0; i < 3; i++) begin
         bus.StepBtn = 1'b1;
         cyc();
         if (en_o === 1'b1) pulses++;
         bus.StepBtn = 1'b0;
         cyc();
         if (en_o === 1'b1) pulses++;
      end
      bus.StepBtn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (en_o === 1'b1) begin
            pulses++;
            first = i;
         end
      end
      chk("t3_press_pulses", 32'(pulses), 32'd1);
      chk("t3_press_delay", 32'((first >= 5) && (first <= 7)), 32'd1);
      pulses = 0;
      for (int i = 0; i < 2; i++) begin
         bus.StepBtn = 1'b0;
         cyc();
         if (en_o === 1'b1) pulses++;
         bus.StepBtn = 1'b1;
         cyc();
         if (en_o === 1'b1) pulses++;
      end
      bus.StepBtn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (en_o === 1'b1) pulses++;
      end
      chk("t3_release_pulses", 32'(pulses), 32'd0);

      // T4: breakpoint at 0x10, then step-resume
      bus.Mode    = 2'b01;
      bus.BrkEn   = 1'b1;
      bus.BrkAddr = 32'h10;
      do_reset();
      cyc();
      chk("t4_halt_en", 32'(en_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t4_run_en", 32'(en_o), 32'd1);
      end
      cyc();
      chk("t4_hit_en", 32'(en_o), 32'd0);
      cyc();
      chk("t4_brk_en", 32'(en_o), 32'd0);
      chk("t4_brkhit", 32'(brk_o), 32'd1);
      chk("t4_brk_halted", 32'(halt_o), 32'd1);
      chk("t4_brk_cnt", 32'(cnt_o), 32'd4);
      chk("t4_brk_pc", bus.PC, 32'h10);
      bus.StepBtn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("t4_wait_en", 32'(en_o), 32'd0);
      end
      cyc();
      chk("t4_step_en", 32'(en_o), 32'd1);
      chk("t4_step_pc", bus.PC, 32'h14);
      cyc();
      chk("t4_resume_en", 32'(en_o), 32'd1);
      chk("t4_resume_brkhit", 32'(brk_o), 32'd0);
      chk("t4_resume_cnt", 32'(cnt_o), 32'd5);
      bus.StepBtn = 1'b0;

      // T5: mode changes while in BRK, step discarded in HALT
      bus.Mode = 2'b01;
      do_reset();
      for (int i = 0; i < 6; i++) cyc();
      cyc();
      chk("t5_brkhit", 32'(brk_o), 32'd1);
      bus.Mode = 2'b10;
      cyc();
      cyc();
      chk("t5_slow_stays_brk", 32'(brk_o), 32'd1);
      chk("t5_slow_stays_en", 32'(en_o), 32'd0);
      bus.Mode = 2'b00;
      cyc();
      cyc();
      chk("t5_halt_brkhit", 32'(brk_o), 32'd0);
      chk("t5_halt_halted", 32'(halt_o), 32'd1);
      pulses = 0;
      bus.StepBtn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (en_o === 1'b1) pulses++;
      end
      chk("t5_halt_step_pulses", 32'(pulses), 32'd0);
      bus.Mode = 2'b11;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (en_o === 1'b1) pulses++;
      end
      chk("t5_no_queued_step", 32'(pulses), 32'd0);
      chk("t5_step_halted", 32'(halt_o), 32'd0);
      bus.StepBtn = 1'b0;

      // T6: CycleCnt wrap on the 4-bit build
      bus.Mode  = 2'b01;
      bus.BrkEn = 1'b0;
      do_reset();
      cyc();
      for (int i = 0; i < 18; i++) begin
         cyc();
         if (i >= 15) chk("t6_wrap_cnt", 32'(cnt_o), 32'(i % 16));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
